// File: rtl/jesd204b_tx_core.sv
// JESD204B subclass-1 single-lane transmit link controller: CGS, 4-multiframe ILAS, then data.
// Follows SYNC~ from the receiver, including re-sync requests and loss of the transceiver.
module jesd204b_tx_core #(
  parameter int unsigned JESD_L         = 1,
  parameter int unsigned JESD_F         = 1,
  parameter int unsigned JESD_K         = 32,
  parameter int unsigned JESD_M         = 2,
  parameter int unsigned JESD_DID       = 0,
  parameter int unsigned JESD_BID       = 0,
  parameter int unsigned JESD_LID       = 0,
  parameter int unsigned USERDATA_WIDTH = 32
) (
  input  logic                      o_gtwiz_reset_clk_freerun_in,
  input  logic                      rst,
  input  logic                      i_gt_tx_ready,
  input  logic                      i_sysref_done,
  input  logic                      i_lmfc,
  input  logic                      i_nsync,
  input  logic [USERDATA_WIDTH-1:0] i_user_data,
  output logic                      o_user_ready,
  output logic [31:0]               o_txdata,
  output logic [3:0]                o_txcharisk,
  output logic                      o_link_up,
  output logic [1:0]                o_state,
  output logic [7:0]                o_resync_cnt
);

  localparam int unsigned FK = JESD_F * JESD_K;

  localparam logic [7:0] KR      = 8'h1C;
  localparam logic [7:0] KA      = 8'h7C;
  localparam logic [7:0] KQ      = 8'h9C;
  localparam logic [7:0] KK      = 8'hBC;
  localparam logic [7:0] LastOct = 8'(FK - 1);
  localparam logic [7:0] LastWrd = 8'(FK - 4);

  localparam logic [7:0] CfgDid  = JESD_DID[7:0];
  localparam logic [7:0] CfgBid  = {4'h0, JESD_BID[3:0]};
  localparam logic [7:0] CfgLid  = {3'h0, JESD_LID[4:0]};
  localparam logic [7:0] CfgL    = 8'(JESD_L - 1);
  localparam logic [7:0] CfgF    = 8'(JESD_F - 1);
  localparam logic [7:0] CfgK    = 8'(JESD_K - 1);
  localparam logic [7:0] CfgM    = 8'(JESD_M - 1);
  localparam logic [7:0] CfgCsN  = 8'h0F;
  localparam logic [7:0] CfgSubN = 8'h2F;
  localparam logic [7:0] CfgVerS = 8'h20;
  localparam logic [7:0] Fchk    = 8'(CfgDid + CfgBid + CfgLid + CfgL + CfgF + CfgK + CfgM +
                                      CfgCsN + CfgSubN + CfgVerS);

  typedef enum logic [1:0] {StIdle = 2'b00, StCgs = 2'b01, StIlas = 2'b10, StData = 2'b11} state_e;

  state_e      state_q;
  logic        sync_meta_q, sync_s_q;
  logic [7:0]  oct_q;
  logic [1:0]  mf_q;
  logic [1:0]  lo_cnt_q;
  logic [7:0]  resync_q;
  logic [31:0] txdata_q;
  logic [3:0]  charisk_q;
  logic        link_up_q;
  logic [31:0] ilas_data;
  logic [3:0]  ilas_k;
  logic [7:0]  idx;

  // Returns {k, octet} for octet position idx of multiframe mf.
  function automatic logic [8:0] ilas_octet(input logic [7:0] pos, input logic [1:0] mf);
    logic [8:0] oct;
    oct = {1'b0, pos};
    if (pos == 8'd0) begin
      oct = {1'b1, KR};
    end else if (pos == LastOct) begin
      oct = {1'b1, KA};
    end else if (mf == 2'd1) begin
      case (pos)
        8'd1:    oct = {1'b1, KQ};
        8'd2:    oct = {1'b0, CfgDid};
        8'd3:    oct = {1'b0, CfgBid};
        8'd4:    oct = {1'b0, CfgLid};
        8'd5:    oct = {1'b0, CfgL};
        8'd6:    oct = {1'b0, CfgF};
        8'd7:    oct = {1'b0, CfgK};
        8'd8:    oct = {1'b0, CfgM};
        8'd9:    oct = {1'b0, CfgCsN};
        8'd10:   oct = {1'b0, CfgSubN};
        8'd11:   oct = {1'b0, CfgVerS};
        8'd12:   oct = 9'h000;
        8'd13:   oct = 9'h000;
        8'd14:   oct = 9'h000;
        8'd15:   oct = {1'b0, Fchk};
        default: oct = {1'b0, pos};
      endcase
    end
    return oct;
  endfunction

  always_comb begin
    ilas_data = '0;
    ilas_k    = '0;
    idx       = '0;
    for (int i = 0; i < 4; i++) begin
      idx = oct_q + 8'(i);
      {ilas_k[i], ilas_data[8*i +: 8]} = ilas_octet(idx, mf_q);
    end
  end

  always_ff @(posedge o_gtwiz_reset_clk_freerun_in or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sync_meta_q <= 1'b0;
      sync_s_q    <= 1'b0;
      oct_q       <= '0;
      mf_q        <= '0;
      lo_cnt_q    <= '0;
      resync_q    <= '0;
      txdata_q    <= '0;
      charisk_q   <= '0;
      link_up_q   <= 1'b0;
    end else begin
      sync_meta_q <= i_nsync;
      sync_s_q    <= sync_meta_q;
      unique case (state_q)
        StIdle: begin
          txdata_q  <= '0;
          charisk_q <= '0;
          link_up_q <= 1'b0;
          if (i_gt_tx_ready && i_sysref_done) state_q <= StCgs;
        end
        StCgs: begin
          txdata_q  <= {4{KK}};
          charisk_q <= 4'hF;
          link_up_q <= 1'b0;
          if (sync_s_q && i_lmfc) begin
            state_q <= StIlas;
            oct_q   <= '0;
            mf_q    <= '0;
          end
        end
        StIlas: begin
          txdata_q  <= ilas_data;
          charisk_q <= ilas_k;
          link_up_q <= 1'b0;
          if (oct_q == LastWrd) begin
            oct_q <= '0;
            mf_q  <= mf_q + 2'd1;
            if (mf_q == 2'd3) state_q <= StData;
          end else begin
            oct_q <= oct_q + 8'd4;
          end
        end
        StData: begin
          txdata_q  <= i_user_data;
          charisk_q <= '0;
          link_up_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase

      // SYNC~ held low for a 4th consecutive cycle is a re-sync request; shorter pulses are noise.
      if ((state_q == StIlas) || (state_q == StData)) begin
        if (!sync_s_q) begin
          if (lo_cnt_q == 2'd3) begin
            state_q  <= StCgs;
            lo_cnt_q <= '0;
            if (resync_q != 8'hFF) resync_q <= resync_q + 8'd1;
          end else begin
            lo_cnt_q <= lo_cnt_q + 2'd1;
          end
        end else begin
          lo_cnt_q <= '0;
        end
      end else begin
        lo_cnt_q <= '0;
      end

      if (!i_gt_tx_ready) state_q <= StIdle;
    end
  end

  assign o_user_ready = (state_q == StData);
  assign o_txdata     = txdata_q;
  assign o_txcharisk  = charisk_q;
  assign o_link_up    = link_up_q;
  assign o_state      = state_q;
  assign o_resync_cnt = resync_q;

endmodule

// File: tb/tb_jesd204b_tx_core.sv
// Directed bench for jesd204b_tx_core with default parameters (F=1, K=32, 8 words per multiframe).
module tb_jesd204b_tx_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gt_ready = 1'b0;
  logic        sysref_done = 1'b0;
  logic        lmfc = 1'b0;
  logic        nsync = 1'b0;
  logic [31:0] user_data = '0;
  logic        user_ready;
  logic [31:0] txdata;
  logic [3:0]  txcharisk;
  logic        link_up;
  logic [1:0]  state;
  logic [7:0]  resync_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] ilas_w [32];
  logic [3:0]  ilas_k [32];

  always #5 clk = ~clk;

  jesd204b_tx_core dut (
    .o_gtwiz_reset_clk_freerun_in(clk),
    .rst                         (rst),
    .i_gt_tx_ready               (gt_ready),
    .i_sysref_done               (sysref_done),
    .i_lmfc                      (lmfc),
    .i_nsync                     (nsync),
    .i_user_data                 (user_data),
    .o_user_ready                (user_ready),
    .o_txdata                    (txdata),
    .o_txcharisk                 (txcharisk),
    .o_link_up                   (link_up),
    .o_state                     (state),
    .o_resync_cnt                (resync_cnt)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({state, txdata, txcharisk, user_ready, link_up, resync_cnt} !== 48'h0) begin
      failures++;
      $display("FAIL reset_outputs: state=%0d data=%h k=%h rdy=%b up=%b rs=%0d, want all 0",
               state, txdata, txcharisk, user_ready, link_up, resync_cnt);
    end
    step(2);
    rst = 1'b0;
    step(2);
    checks++;
    if (state !== 2'd0 || txdata !== 32'h0) begin
      failures++;
      $display("FAIL idle_hold: state=%0d data=%h, want 0 / 00000000", state, txdata);
    end
  endtask

  task automatic test_cgs();
    gt_ready    = 1'b1;
    sysref_done = 1'b1;
    nsync       = 1'b0;
    step(1);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL cgs_state: got %0d want 1", state);
    end
    step(1);
    checks++;
    if (txdata !== 32'hBCBCBCBC || txcharisk !== 4'hF) begin
      failures++;
      $display("FAIL cgs_data: got %h/%h want bcbcbcbc/f", txdata, txcharisk);
    end
    // SYNC~ released but no LMFC yet: must stay in CGS.
    nsync = 1'b1;
    step(3);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL cgs_wait_lmfc: got %0d want 1", state);
    end
  endtask

  task automatic test_ilas();
    user_data = 32'hDEADBEEF;
    lmfc = 1'b1;
    step(1);
    lmfc = 1'b0;
    checks++;
    if (state !== 2'd2 || txdata !== 32'hBCBCBCBC) begin
      failures++;
      $display("FAIL ilas_entry: state=%0d data=%h want 2 / bcbcbcbc", state, txdata);
    end
    for (int i = 0; i < 32; i++) begin
      lmfc = (i == 9);
      step(1);
      ilas_w[i] = txdata;
      ilas_k[i] = txcharisk;
    end
    lmfc = 1'b0;
    checks++;
    if (ilas_w[0] !== 32'h0302011C || ilas_k[0] !== 4'h1) begin
      failures++;
      $display("FAIL ilas_mf0_w0: got %h/%h want 0302011c/1", ilas_w[0], ilas_k[0]);
    end
    checks++;
    if (ilas_w[1] !== 32'h07060504 || ilas_k[1] !== 4'h0) begin
      failures++;
      $display("FAIL ilas_mf0_w1: got %h/%h want 07060504/0", ilas_w[1], ilas_k[1]);
    end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (ilas_w[8*m+7] !== 32'h7C1E1D1C || ilas_k[8*m+7] !== 4'h8) begin
        failures++;
        $display("FAIL ilas_a_mf%0d: got %h/%h want 7c1e1d1c/8", m, ilas_w[8*m+7], ilas_k[8*m+7]);
      end
      checks++;
      if (ilas_w[8*m][7:0] !== 8'h1C || ilas_k[8*m][0] !== 1'b1) begin
        failures++;
        $display("FAIL ilas_r_mf%0d: got %h/%h want 1c/1", m, ilas_w[8*m][7:0], ilas_k[8*m][0]);
      end
    end
    checks++;
    if (ilas_w[8] !== 32'h00009C1C || ilas_k[8] !== 4'h3) begin
      failures++;
      $display("FAIL cfg_w0: got %h/%h want 00009c1c/3", ilas_w[8], ilas_k[8]);
    end
    checks++;
    if (ilas_w[9] !== 32'h1F000000 || ilas_k[9] !== 4'h0) begin
      failures++;
      $display("FAIL cfg_w1: got %h/%h want 1f000000/0", ilas_w[9], ilas_k[9]);
    end
    checks++;
    if (ilas_w[10] !== 32'h202F0F01 || ilas_k[10] !== 4'h0) begin
      failures++;
      $display("FAIL cfg_w2: got %h/%h want 202f0f01/0", ilas_w[10], ilas_k[10]);
    end
    checks++;
    if (ilas_w[11] !== 32'h7E000000 || ilas_k[11] !== 4'h0) begin
      failures++;
      $display("FAIL cfg_w3_fchk: got %h/%h want 7e000000/0", ilas_w[11], ilas_k[11]);
    end
    checks++;
    if (ilas_w[12] !== 32'h13121110 || ilas_w[17] !== 32'h07060504) begin
      failures++;
      $display("FAIL ilas_index_octets: got %h %h want 13121110 07060504", ilas_w[12], ilas_w[17]);
    end
    checks++;
    if (state !== 2'd3 || user_ready !== 1'b1 || link_up !== 1'b0) begin
      failures++;
      $display("FAIL ilas_last_cycle: state=%0d rdy=%b up=%b want 3/1/0", state, user_ready, link_up);
    end
    step(1);
    checks++;
    if (txdata !== 32'hDEADBEEF || txcharisk !== 4'h0 || link_up !== 1'b1) begin
      failures++;
      $display("FAIL data_start: got %h/%h up=%b want deadbeef/0/1", txdata, txcharisk, link_up);
    end
  endtask

  task automatic test_data();
    user_data = 32'h12345678;
    step(1);
    user_data = 32'hA5A55A5A;
    checks++;
    if (txdata !== 32'h12345678 || txcharisk !== 4'h0) begin
      failures++;
      $display("FAIL data_pass1: got %h/%h want 12345678/0", txdata, txcharisk);
    end
    sysref_done = 1'b0;
    step(1);
    checks++;
    if (txdata !== 32'hA5A55A5A || state !== 2'd3) begin
      failures++;
      $display("FAIL data_pass2: got %h st=%0d want a5a55a5a/3", txdata, state);
    end
    sysref_done = 1'b1;
  endtask

  task automatic test_sync_glitch();
    nsync = 1'b0;
    step(3);
    nsync = 1'b1;
    step(6);
    checks++;
    if (state !== 2'd3 || resync_cnt !== 8'd0 || link_up !== 1'b1) begin
      failures++;
      $display("FAIL sync_glitch: st=%0d rs=%0d up=%b want 3/0/1", state, resync_cnt, link_up);
    end
  endtask

  task automatic test_resync();
    nsync = 1'b0;
    step(4);
    nsync = 1'b1;
    step(1);
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL resync_early: st=%0d want 3", state);
    end
    step(1);
    checks++;
    if (state !== 2'd1 || resync_cnt !== 8'd1) begin
      failures++;
      $display("FAIL resync_enter: st=%0d rs=%0d want 1/1", state, resync_cnt);
    end
    step(2);
    checks++;
    if (txdata !== 32'hBCBCBCBC || txcharisk !== 4'hF || link_up !== 1'b0) begin
      failures++;
      $display("FAIL resync_cgs: got %h/%h up=%b want bcbcbcbc/f/0", txdata, txcharisk, link_up);
    end
  endtask

  task automatic test_gt_drop();
    lmfc = 1'b1;
    step(1);
    lmfc = 1'b0;
    step(3);
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL gt_drop_pre: st=%0d want 2", state);
    end
    gt_ready = 1'b0;
    step(1);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL gt_drop_state: st=%0d want 0", state);
    end
    step(1);
    checks++;
    if (txdata !== 32'h0 || txcharisk !== 4'h0) begin
      failures++;
      $display("FAIL gt_drop_out: got %h/%h want 00000000/0", txdata, txcharisk);
    end
    gt_ready = 1'b1;
    step(1);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL gt_return: st=%0d want 1", state);
    end
  endtask

  task automatic test_async_reset();
    step(2);
    lmfc = 1'b1;
    step(1);
    lmfc = 1'b0;
    user_data = 32'hCAFEF00D;
    step(34);
    checks++;
    if (link_up !== 1'b1 || txdata !== 32'hCAFEF00D || resync_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rst_pre: up=%b data=%h rs=%0d want 1/cafef00d/1", link_up, txdata, resync_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({state, txdata, txcharisk, user_ready, link_up, resync_cnt} !== 48'h0) begin
      failures++;
      $display("FAIL async_reset: st=%0d data=%h k=%h rdy=%b up=%b rs=%0d want all 0",
               state, txdata, txcharisk, user_ready, link_up, resync_cnt);
    end
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cgs();
    test_ilas();
    test_data();
    test_sync_glitch();
    test_resync();
    test_gt_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
